// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues icache reads. It buffers a
// word returned during a stall and applies redirects without ever moving the
// address of a request that is still outstanding.
module fetch_unit #(
    parameter logic [31:0] PC_INIT    = 32'h0000_0000,
    parameter int          WORD_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] IF_instr_in,
    output logic [31:0] IF_pc4_in,
    output logic        fetch_valid,
    output logic        if_flush
);

    localparam logic [31:0] STEP = 32'(WORD_BYTES);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    // Per-state outputs before reset gating.
    logic        iren_s;
    logic        valid_s;
    logic        flush_s;
    logic [31:0] instr_s;

    // State register; reset discards any held word or pending redirect.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= FETCH;
            pc_q         <= PC_INIT;
            hold_instr_q <= 32'h0;
            pend_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_instr_q <= hold_instr_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    // Next-state and per-state outputs; halt overrides everything else.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_instr_d = hold_instr_q;
        pend_pc_d    = pend_pc_q;
        iren_s       = 1'b0;
        valid_s      = 1'b0;
        flush_s      = 1'b0;
        instr_s      = 32'h0;

        unique case (state_q)
            FETCH: begin
                iren_s  = 1'b1;
                instr_s = imemload;
                valid_s = ihit;
                if (redirect_valid) begin
                    flush_s = 1'b1;
                    valid_s = 1'b0;
                    if (ihit) begin
                        // Request completed this cycle, so the PC is free to move.
                        pc_d = redirect_pc;
                    end else begin
                        // Keep the outstanding address stable; retarget after it returns.
                        pend_pc_d = redirect_pc;
                        state_d   = DRAIN;
                    end
                end else if (ihit) begin
                    if (stall) begin
                        hold_instr_d = imemload;
                        state_d      = HOLD;
                    end else begin
                        pc_d = pc_q + STEP;
                    end
                end
            end
            HOLD: begin
                instr_s = hold_instr_q;
                valid_s = 1'b1;
                if (redirect_valid) begin
                    flush_s = 1'b1;
                    valid_s = 1'b0;
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + STEP;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                iren_s = 1'b1;
                if (redirect_valid) begin
                    flush_s   = 1'b1;
                    pend_pc_d = redirect_pc;
                    if (ihit) begin
                        pc_d    = redirect_pc;
                        state_d = FETCH;
                    end
                end else if (ihit) begin
                    // Word for the stale address is discarded.
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (halt) begin
            state_d      = HALTED;
            pc_d         = pc_q;
            hold_instr_d = hold_instr_q;
            pend_pc_d    = pend_pc_q;
            flush_s      = 1'b0;
        end
    end

    // Output gating: all qualifiers quiet while reset is held.
    always_comb begin
        imemaddr    = pc_q;
        IF_pc4_in   = RST ? (PC_INIT + STEP) : (pc_q + STEP);
        iREN        = RST ? 1'b0 : iren_s;
        fetch_valid = RST ? 1'b0 : valid_s;
        if_flush    = RST ? 1'b0 : flush_s;
        IF_instr_in = RST ? 32'h0 : instr_s;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected fetch words into a
// scoreboard; a negedge monitor pops and compares on every fetch_valid.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] IF_instr_in;
    logic [31:0] IF_pc4_in;
    logic        fetch_valid;
    logic        if_flush;

    fetch_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .imemload       (imemload),
        .iREN           (iREN),
        .imemaddr       (imemaddr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .IF_instr_in    (IF_instr_in),
        .IF_pc4_in      (IF_pc4_in),
        .fetch_valid    (fetch_valid),
        .if_flush       (if_flush)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of inputs, check the control outputs, queue any expected fetch.
    task automatic cyc(input string nm, input logic h, input logic [31:0] ld,
                       input logic st, input logic rv, input logic [31:0] rpc,
                       input logic hl, input logic e_ren, input logic [31:0] e_addr,
                       input logic e_val, input logic e_fl,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4);
        ihit           = h;
        imemload       = ld;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hl;
        #3;
        chk({nm, ".iREN"}, {31'h0, iREN}, {31'h0, e_ren});
        chk({nm, ".imemaddr"}, imemaddr, e_addr);
        chk({nm, ".fetch_valid"}, {31'h0, fetch_valid}, {31'h0, e_val});
        chk({nm, ".if_flush"}, {31'h0, if_flush}, {31'h0, e_fl});
        if (e_val) sb_q.push_back('{instr: e_instr, pc4: e_pc4});
        $display("cycle %-10s addr=%h ren=%b valid=%b flush=%b instr=%h pc4=%h",
                 nm, imemaddr, iREN, fetch_valid, if_flush, IF_instr_in, IF_pc4_in);
    endtask

    // Scoreboard monitor: every presented fetch must match the next queued word.
    always @(negedge CLK) begin
        if (fetch_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_fetch: got instr %h pc4 %h, required none",
                         IF_instr_in, IF_pc4_in);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb.instr", IF_instr_in, mon_e.instr);
                chk("sb.pc4", IF_pc4_in, mon_e.pc4);
            end
        end
    end

    initial begin
        RST            = 1'b1;
        ihit           = 1'b1;
        imemload       = 32'hDEAD_BEEF;
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0900;
        halt           = 1'b0;
        #3;
        chk("rst.iREN", {31'h0, iREN}, 32'h0);
        chk("rst.fetch_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst.if_flush", {31'h0, if_flush}, 32'h0);
        chk("rst.instr", IF_instr_in, 32'h0);
        chk("rst.pc4", IF_pc4_in, 32'h4);
        chk("rst.imemaddr", imemaddr, 32'h0);
        tick();
        tick();
        RST = 1'b0;

        // Straight-line fetch from PC_INIT
        for (int k = 0; k < 4; k++) begin
            cyc("seq", 1, 32'h1000 + 32'(4 * k), 0, 0, 0, 0,
                1, 32'(4 * k), 1, 0, 32'h1000 + 32'(4 * k), 32'(4 * k + 4));
            tick();
        end

        // Stall with a returned word: three stall cycles, then release
        cyc("hold0", 1, 32'h2008_0005, 1, 0, 0, 0, 1, 32'h10, 1, 0, 32'h2008_0005, 32'h14);
        tick();
        for (int k = 0; k < 2; k++) begin
            cyc("hold", 0, 0, 1, 0, 0, 0, 0, 32'h10, 1, 0, 32'h2008_0005, 32'h14);
            tick();
        end
        cyc("hold_rel", 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 0, 32'h2008_0005, 32'h14);
        tick();
        for (int a = 32'h14; a <= 32'h1C; a += 4) begin
            cyc("seq2", 1, 32'h2000 + 32'(a), 0, 0, 0, 0,
                1, 32'(a), 1, 0, 32'h2000 + 32'(a), 32'(a + 4));
            tick();
        end

        // Redirect while a miss is outstanding, then a newer redirect in DRAIN
        cyc("rd_miss", 0, 0, 0, 1, 32'h100, 0, 1, 32'h20, 0, 1, 0, 0);
        tick();
        cyc("drain", 0, 0, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0);
        tick();
        cyc("drain_rd2", 0, 0, 0, 1, 32'h200, 0, 1, 32'h20, 0, 1, 0, 0);
        tick();
        cyc("drain_hit", 1, 32'h0BAD, 0, 0, 0, 0, 1, 32'h20, 0, 0, 0, 0);
        tick();

        // Redirect on a hit, then redirect out of HOLD
        cyc("rd_hit", 1, 32'h3333, 0, 1, 32'h300, 0, 1, 32'h200, 0, 1, 0, 0);
        tick();
        cyc("hold1", 1, 32'h4444, 1, 0, 0, 0, 1, 32'h300, 1, 0, 32'h4444, 32'h304);
        tick();
        cyc("hold_rd", 0, 0, 1, 1, 32'h400, 0, 0, 32'h300, 0, 1, 0, 0);
        tick();

        // Halt with a coincident redirect, then stay frozen
        cyc("halt", 0, 0, 0, 1, 32'h500, 1, 1, 32'h400, 0, 0, 0, 0);
        tick();
        for (int k = 0; k < 12; k++) begin
            cyc("halted", 1, 32'h55, k[0], 1, 32'h600, 0, 0, 32'h400, 0, 0, 0, 0);
            tick();
        end
        RST            = 1'b1;
        redirect_valid = 1'b0;
        #1;
        chk("arst.iREN", {31'h0, iREN}, 32'h0);
        chk("arst.imemaddr", imemaddr, 32'h0);
        chk("arst.pc4", IF_pc4_in, 32'h4);
        tick();
        RST = 1'b0;
        cyc("post_rst", 1, 32'h7000, 0, 0, 0, 0, 1, 32'h0, 1, 0, 32'h7000, 32'h4);
        tick();

        // Reset while draining loses the pending redirect
        cyc("rd_miss2", 0, 0, 0, 1, 32'h700, 0, 1, 32'h4, 0, 1, 0, 0);
        tick();
        ihit           = 1'b0;
        redirect_valid = 1'b0;
        RST            = 1'b1;
        #1;
        chk("arst2.imemaddr", imemaddr, 32'h0);
        tick();
        RST = 1'b0;
        cyc("post_rst2", 1, 32'h7100, 0, 0, 0, 0, 1, 32'h0, 1, 0, 32'h7100, 32'h4);
        tick();
        cyc("after_rst2", 0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0, 0);
        tick();

        // PC wrap at the top of the address space
        cyc("to_wrap", 1, 32'h1, 0, 1, 32'hFFFF_FFFC, 0, 1, 32'h4, 0, 1, 0, 0);
        tick();
        cyc("wrap", 1, 32'h5A, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h5A, 32'h0);
        tick();
        cyc("wrapped", 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0, 0);
        tick();

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the PC, issues instruction reads to the icache (iREN/imemaddr/ihit handshake) and presents IF_instr_in/IF_pc4_in with a valid qualifier. It absorbs stalls by buffering a returned word, and applies branch/jump redirects without ever changing the address of an in-flight request. It freezes permanently on halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
WORD_BYTES, 4, PC increment per instruction.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
ihit  in  1  icache: imemload valid for current imemaddr this cycle.
imemload  in  32  icache read data.
iREN  out  1  icache read request.
imemaddr  out  32  icache address; equals PC.
stall  in  1  hazard unit: IF/ID not enabled this cycle (inverse of IF_EN).
redirect_valid  in  1  taken branch/jump/JR resolved downstream, 1-cycle pulse.
redirect_pc  in  32  redirect target.
halt  in  1  halt reached commit (MEM_halt).
IF_instr_in  out  32  instruction to IF/ID.
IF_pc4_in  out  32  PC+4 of that instruction.
fetch_valid  out  1  IF_instr_in/IF_pc4_in valid this cycle.
if_flush  out  1  flush request for IF/ID (drives IF_FLUSH).

Behaviour:
- State: pc[31:0], hold_instr[31:0], pend_pc[31:0], FSM {FETCH, HOLD, DRAIN, HALTED}.
- Reset (async): pc=PC_INIT, state=FETCH, hold_instr=0, pend_pc=0. While RST=1: iREN=0, fetch_valid=0, if_flush=0, IF_instr_in=0, IF_pc4_in=PC_INIT+4.
- imemaddr=pc always; IF_pc4_in=pc+WORD_BYTES (mod 2^32, wraps 32'hFFFF_FFFC→0).
- FETCH: iREN=1. IF_instr_in=imemload; fetch_valid=ihit.
  - ihit & !stall: pc<=pc+4. Stay FETCH.
  - ihit & stall: hold_instr<=imemload; →HOLD.
  - !ihit: pc held.
- HOLD: iREN=0; IF_instr_in=hold_instr; fetch_valid=1. !stall: pc<=pc+4, →FETCH. stall: remain.
- DRAIN: iREN=1 (same address, request kept stable); fetch_valid=0. ihit: returned word discarded, pc<=pend_pc, →FETCH. No ihit: remain.
- Redirect (priority over all non-halt transitions): if_flush=redirect_valid combinationally, in any state except HALTED; fetch_valid forced 0 that cycle.
  - FETCH with ihit, or HOLD: pc<=redirect_pc, →FETCH (held word dropped).
  - FETCH without ihit: pend_pc<=redirect_pc, →DRAIN.
  - DRAIN: pend_pc<=redirect_pc (newest wins). If ihit in same cycle, pc<=redirect_pc, →FETCH.
- Halt (highest priority): halt=1 in any state → HALTED next edge; the same-cycle redirect is ignored and if_flush=0. HALTED: iREN=0, fetch_valid=0, if_flush=0, pc frozen. Exits only via RST.
- Reset mid-DRAIN/HOLD: all state discarded immediately; pending redirect lost.
- At most one outstanding request; pc never changes while iREN=1 and ihit=0.

Test Plan:
- Reset, PC_INIT=0, ihit=1 constant, stall=0 → imemaddr 0,4,8,C on successive cycles; fetch_valid=1; IF_pc4_in 4,8,C,10.
- pc=0x10, ihit with imemload=0x2008_0005, stall=1 for 3 cycles → HOLD, iREN=0, IF_instr_in=0x2008_0005 with fetch_valid=1 for all 3 cycles; imemaddr fetches 0x14 the cycle after stall drops.
- pc=0x20, ihit=0, redirect_valid to 0x100 → if_flush=1 one cycle; imemaddr stays 0x20 until ihit, then that word is discarded (fetch_valid=0) and next imemaddr=0x100.
- In DRAIN, second redirect to 0x200 before ihit → after ihit, pc=0x200, not 0x100.
- halt=1 coincident with redirect_valid → HALTED next cycle, if_flush=0, iREN=0, pc unchanged for 10+ cycles; RST restores pc=PC_INIT and iREN=1.
- pc=32'hFFFF_FFFC, ihit, !stall → IF_pc4_in=0, next imemaddr=0.
